step_sequencer: RTL

Pattern-driven step sequencer that generates the per-voice `note` and `gate` signals for the voice bank, replacing free-running counter gating. It advances through a programmable pattern at a tempo derived from the sample tick. Each step can trigger, or leave untouched, each of the voices. Its outputs connect directly to the `note`/`gate` inputs of the voice instances ahead of the mixers and DAC.

---
 rtl/step_sequencer_pkg.sv | 19 +
 rtl/step_sequencer_pattern_store.sv | 51 +++++
 rtl/step_sequencer.sv | 153 +++++++++++++++
 3 files changed

// File: rtl/step_sequencer_pkg.sv
// Shared definitions for the step sequencer: default sizes, FSM encoding and
// the clamp limits applied to the timing and length controls.
package step_sequencer_pkg;

  localparam int VOICES_DEF = 4;
  localparam int STEPS_DEF  = 16;
  localparam int NOTE_W_DEF = 8;

  typedef enum logic {
    ST_STOP = 1'b0,
    ST_PLAY = 1'b1
  } seq_state_t;

  // Smallest usable step is two ticks so that one gate tick and one low tick fit.
  localparam logic [15:0] MIN_STEP_LEN = 16'd2;
  localparam logic [15:0] MIN_GATE_LEN = 16'd1;
  localparam int          MIN_LENGTH   = 1;

endpackage

// File: rtl/step_sequencer_pattern_store.sv
// Pattern memory: STEPS x VOICES entries of {on, note}, one write port and
// one read of all voices at a single step, with write-first bypass.
module pattern_store
  import step_sequencer_pkg::*;
#(
  parameter int VOICES = VOICES_DEF,
  parameter int STEPS  = STEPS_DEF,
  parameter int NOTE_W = NOTE_W_DEF
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       wr_en,
  input  logic [$clog2(STEPS)-1:0]   wr_step,
  input  logic [$clog2(VOICES)-1:0]  wr_voice,
  input  logic                       wr_on,
  input  logic [NOTE_W-1:0]          wr_note,
  input  logic [$clog2(STEPS)-1:0]   rd_step,
  output logic [VOICES-1:0]          rd_on,
  output logic [VOICES*NOTE_W-1:0]   rd_note
);

  logic [VOICES-1:0] on_mem   [STEPS];
  logic [NOTE_W-1:0] note_mem [STEPS][VOICES];

  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int s = 0; s < STEPS; s++) on_mem[s] <= '0;
    end else if (wr_en) begin
      on_mem[wr_step][wr_voice] <= wr_on;
    end
  end

  // Note fields carry no reset; a write during reset is still dropped.
  always_ff @(posedge clk) begin
    if (rst && wr_en) note_mem[wr_step][wr_voice] <= wr_note;
  end

  always_comb begin
    rd_on   = '0;
    rd_note = '0;
    for (int v = 0; v < VOICES; v++) begin
      rd_on[v]                    = on_mem[rd_step][v];
      rd_note[v*NOTE_W +: NOTE_W] = note_mem[rd_step][v];
      if (wr_en && (wr_step == rd_step) && (int'(wr_voice) == v)) begin
        rd_on[v]                    = wr_on;
        rd_note[v*NOTE_W +: NOTE_W] = wr_note;
      end
    end
  end

endmodule

// File: rtl/step_sequencer.sv
// Pattern-driven step sequencer producing per-voice note/gate for the voice
// bank; all state moves only on sample ticks.
module step_sequencer
  import step_sequencer_pkg::*;
#(
  parameter int VOICES = VOICES_DEF,
  parameter int STEPS  = STEPS_DEF,
  parameter int NOTE_W = NOTE_W_DEF
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         sample_tick,
  input  logic                         run,
  input  logic [15:0]                  step_len,
  input  logic [15:0]                  gate_len,
  input  logic [$clog2(STEPS):0]       length,
  input  logic                         wr_en,
  input  logic [$clog2(STEPS)-1:0]     wr_step,
  input  logic [$clog2(VOICES)-1:0]    wr_voice,
  input  logic                         wr_on,
  input  logic [NOTE_W-1:0]            wr_note,
  output logic [VOICES*NOTE_W-1:0]     note,
  output logic [VOICES-1:0]            gate,
  output logic [$clog2(STEPS)-1:0]     step,
  output logic                         step_strobe
);

  localparam int SW = $clog2(STEPS);
  localparam int LW = SW + 1;

  seq_state_t state, state_next;

  logic [15:0]          tick_cnt;
  logic [15:0]          tick_inc;
  logic [15:0]          step_len_eff;
  logic [15:0]          gate_len_eff;
  logic [LW-1:0]        length_eff;
  logic [LW-1:0]        step_inc;
  logic [SW-1:0]        next_step;
  logic [SW-1:0]        fire_step;
  logic                 fire;
  logic                 advance;
  logic                 halt;
  logic                 gate_clear;
  logic [VOICES-1:0]    rd_on;
  logic [VOICES*NOTE_W-1:0] rd_note;

  always_comb begin
    step_len_eff = (step_len < MIN_STEP_LEN) ? MIN_STEP_LEN : step_len;
    if (gate_len < MIN_GATE_LEN)
      gate_len_eff = MIN_GATE_LEN;
    else if (gate_len >= step_len_eff)
      gate_len_eff = step_len_eff - 16'd1;
    else
      gate_len_eff = gate_len;

    if (length == '0)
      length_eff = LW'(MIN_LENGTH);
    else if (length > LW'(STEPS))
      length_eff = LW'(STEPS);
    else
      length_eff = length;

    tick_inc  = tick_cnt + 16'd1;
    step_inc  = {1'b0, step} + LW'(1);
    next_step = (step_inc >= length_eff) ? '0 : step_inc[SW-1:0];
  end

  always_ff @(posedge clk) begin
    if (!rst) state <= ST_STOP;
    else      state <= state_next;
  end

  // Comparisons use >= so a step_len/gate_len cut mid-step still fires or
  // clears on the next tick instead of waiting for the counter to wrap.
  always_comb begin
    state_next = state;
    fire       = 1'b0;
    advance    = 1'b0;
    halt       = 1'b0;
    gate_clear = 1'b0;
    fire_step  = next_step;
    if (sample_tick) begin
      case (state)
        ST_STOP: begin
          if (run) begin
            state_next = ST_PLAY;
            fire       = 1'b1;
            fire_step  = '0;
          end
        end
        ST_PLAY: begin
          if (!run) begin
            state_next = ST_STOP;
            halt       = 1'b1;
          end else if (tick_inc >= step_len_eff) begin
            fire = 1'b1;
          end else begin
            advance    = 1'b1;
            gate_clear = (tick_inc >= gate_len_eff);
          end
        end
        default: state_next = ST_STOP;
      endcase
    end
  end

  pattern_store #(
    .VOICES (VOICES),
    .STEPS  (STEPS),
    .NOTE_W (NOTE_W)
  ) u_pattern_store (
    .clk      (clk),
    .rst      (rst),
    .wr_en    (wr_en),
    .wr_step  (wr_step),
    .wr_voice (wr_voice),
    .wr_on    (wr_on),
    .wr_note  (wr_note),
    .rd_step  (fire_step),
    .rd_on    (rd_on),
    .rd_note  (rd_note)
  );

  // Voices not triggered on a fire keep their previous note for the release tail.
  always_ff @(posedge clk) begin
    if (!rst) begin
      tick_cnt    <= '0;
      step        <= '0;
      gate        <= '0;
      note        <= '0;
      step_strobe <= 1'b0;
    end else begin
      step_strobe <= 1'b0;
      if (fire) begin
        tick_cnt    <= '0;
        step        <= fire_step;
        step_strobe <= 1'b1;
        gate        <= rd_on;
        for (int v = 0; v < VOICES; v++) begin
          if (rd_on[v]) note[v*NOTE_W +: NOTE_W] <= rd_note[v*NOTE_W +: NOTE_W];
        end
      end else if (advance) begin
        tick_cnt <= tick_inc;
        if (gate_clear) gate <= '0;
      end else if (halt) begin
        tick_cnt <= '0;
        gate     <= '0;
      end
    end
  end

endmodule
